// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-stage definitions: reset vector, word width, fetch FSM encoding
// and the tagged FIFO entry layout.
package if_fetch_buffer_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          INSTR_W  = 32;

    // Encoding is also decoded by the hazard unit for debug visibility.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] word;
        logic [31:0]        pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// DEPTH-entry FIFO of PC-tagged instruction words with synchronous clear.
// Storage carries no reset; only pointers and occupancy are reset.
module fetch_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  fetch_entry_t        wr_data,
    output fetch_entry_t        rd_data,
    output logic [PTR_W:0]      count
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues one word fetch at a time for PC, tags returned
// words with their PC and buffers them for ID behind a valid/ready handshake.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        PC,
    output logic               PC_en,
    input  logic               flush,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               id_ready
);

    localparam logic [PTR_W+1:0] OCC_LIMIT = (PTR_W+2)'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W:0]   count;
    logic [PTR_W+1:0] occupancy;
    fetch_entry_t     head, wr_entry;
    logic             inflight, space, issue, push, pop;

    always_comb begin
        instr_valid = (count != '0);
        pop         = instr_valid & id_ready & ~flush;
        inflight    = (state_q == FS_WAIT);
        push        = inflight & imem_rvalid & ~flush;
        // Credit: buffered entries plus the response still owed must leave a slot.
        occupancy   = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight}
                    - {{(PTR_W+1){1'b0}}, pop};
        space       = (occupancy < OCC_LIMIT);
        // Gating on reset keeps the request low the instant reset asserts.
        issue       = reset & ~flush & space &
                      ((state_q == FS_IDLE) | ((state_q == FS_WAIT) & imem_rvalid));
    end

    always_comb begin
        state_d  = state_q;
        req_pc_d = issue ? PC : req_pc_q;
        case (state_q)
            FS_IDLE: begin
                if (issue) state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (flush)            state_d = imem_rvalid ? FS_IDLE : FS_DROP;
                else if (imem_rvalid) state_d = issue ? FS_WAIT : FS_IDLE;
            end
            FS_DROP: begin
                if (imem_rvalid) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FS_IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        wr_entry.word = imem_rdata;
        wr_entry.pc   = req_pc_q;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count)
    );

    always_comb begin
        imem_req  = issue;
        PC_en     = issue;
        imem_addr = reset ? word_align(PC) : '0;
        instr     = instr_valid ? head.word : '0;
        instr_pc  = instr_valid ? head.pc   : '0;
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a PC-register model, a latency-
// programmable memory model and a scoreboard of expected FIFO contents.
module tb_if_fetch_buffer;
    import if_fetch_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic        PC_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        id_ready;

    always #5 clk = ~clk;

    if_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .PC_en       (PC_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .id_ready    (id_ready)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;
    bit          mem_busy;
    bit          mem_killed;
    int          mem_cnt;
    logic [31:0] mem_pc;
    logic [31:0] flush_target;
    int          n_pops;
    int          n_reqs;
    logic [31:0] pop_pc [3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, update the models,
    // then drive the next cycle's inputs just after the rising edge.
    task automatic step();
        bit   req, pv, flush_now, exp_issue;
        int   credit;
        exp_t e;
        @(negedge clk);
        req       = imem_req;
        pv        = instr_valid && id_ready && !flush;
        flush_now = flush;
        chk("pc_en_eq_req", 64'(PC_en), 64'(imem_req));
        if (exp_q.size() != 0) begin
            chk("head_valid", 64'(instr_valid), 64'(1));
            chk("head_instr", 64'(instr), 64'(exp_q[0].word));
            chk("head_pc", 64'(instr_pc), 64'(exp_q[0].pc));
        end else begin
            chk("empty_valid", 64'(instr_valid), 64'(0));
            chk("empty_head", {instr, instr_pc}, 64'(0));
        end
        if (!reset) chk("rst_addr", 64'(imem_addr), 64'(0));
        credit    = exp_q.size() + ((mem_busy && !mem_killed) ? 1 : 0) - (pv ? 1 : 0);
        exp_issue = reset && !flush && (credit < DEPTH) &&
                    (!mem_busy || (imem_rvalid && !mem_killed));
        chk("issue", 64'(imem_req), 64'(exp_issue));
        if (req) chk("req_addr", 64'(imem_addr), 64'({PC[31:2], 2'b00}));
        if (pv && exp_q.size() != 0) begin
            if (n_pops < 3) pop_pc[n_pops] = instr_pc;
            n_pops++;
            void'(exp_q.pop_front());
        end
        if (imem_rvalid && mem_busy) begin
            if (!mem_killed && !flush) begin
                e.word = mem_word(mem_pc);
                e.pc   = mem_pc;
                exp_q.push_back(e);
            end
            mem_busy = 1'b0;
        end
        if (flush) begin
            exp_q.delete();
            if (mem_busy) mem_killed = 1'b1;
        end
        if (req) begin
            n_reqs++;
            mem_busy   = 1'b1;
            mem_killed = 1'b0;
            mem_cnt    = lat;
            mem_pc     = PC;
        end
        @(posedge clk);
        #1;
        if (flush_now) PC = flush_target;
        else if (req)  PC = PC + 32'd4;
        flush = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_pc);
            end
        end
    endtask

    initial begin
        reset = 1'b0; PC = RESET_PC; flush = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; lat = 1; flush_target = '0;
        mem_busy = 1'b0; mem_killed = 1'b0; mem_cnt = 0; mem_pc = '0;
        n_pops = 0; n_reqs = 0;
        for (int i = 0; i < 3; i++) pop_pc[i] = '0;

        // Reset held for three cycles, then the first fetch.
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("first_req", 64'(imem_req), 64'(1));
        chk("first_addr", 64'(imem_addr), 64'(RESET_PC));
        step();
        step();
        #1;
        chk("first_valid", 64'(instr_valid), 64'(1));
        chk("first_pc", 64'(instr_pc), 64'(RESET_PC));
        chk("first_instr", 64'(instr), 64'(mem_word(RESET_PC)));

        // Stall: FIFO fills to DEPTH and the PC is held.
        repeat (4) step();
        #1;
        chk("stall_valid", 64'(instr_valid), 64'(1));
        chk("stall_req", 64'(imem_req), 64'(0));
        chk("stall_pc_en", 64'(PC_en), 64'(0));
        chk("stall_head", 64'(instr_pc), 64'(32'h3000));
        chk("stall_count", 64'(dut.count), 64'(2));

        // Release: streaming one instruction per cycle.
        n_pops = 0; n_reqs = 0;
        id_ready = 1'b1;
        repeat (10) step();
        chk("stream_reqs", 64'(n_reqs), 64'(10));
        chk("stream_pop0", 64'(pop_pc[0]), 64'(32'h3000));
        chk("stream_pop1", 64'(pop_pc[1]), 64'(32'h3004));
        chk("stream_pop2", 64'(pop_pc[2]), 64'(32'h3008));

        // Flush while a slow response is outstanding.
        lat = 3;
        for (int i = 0; i < 20 && !(mem_busy && !mem_killed && !imem_rvalid); i++) step();
        flush = 1'b1;
        flush_target = 32'h3040;
        step();
        #1;
        chk("flush_drop", 64'(dut.state_q), 64'(FS_DROP));
        chk("flush_valid", 64'(instr_valid), 64'(0));
        n_pops = 0; pop_pc[0] = '0;
        for (int i = 0; i < 30 && n_pops == 0; i++) step();
        chk("redirect_pc", 64'(pop_pc[0]), 64'(32'h3040));

        // Flush coincident with a response and a pop, one entry buffered.
        lat = 1;
        id_ready = 1'b0;
        for (int i = 0; i < 20 && !(imem_rvalid && mem_busy && !mem_killed && exp_q.size() == 1); i++)
            step();
        flush = 1'b1;
        flush_target = 32'h3100;
        id_ready = 1'b1;
        #1;
        chk("coinc_no_issue", 64'(imem_req), 64'(0));
        step();
        #1;
        chk("coinc_count", 64'(dut.count), 64'(0));
        chk("coinc_valid", 64'(instr_valid), 64'(0));
        chk("coinc_state", 64'(dut.state_q), 64'(FS_IDLE));
        chk("coinc_next_req", 64'(imem_req), 64'(1));
        chk("coinc_next_addr", 64'(imem_addr), 64'(32'h3100));

        // Asynchronous reset between edges with an entry buffered and a fetch pending.
        lat = 3;
        id_ready = 1'b0;
        for (int i = 0; i < 20 && !(exp_q.size() >= 1 && mem_busy && !mem_killed && !imem_rvalid); i++)
            step();
        chk("arst_setup_state", 64'(dut.state_q), 64'(FS_WAIT));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'(0));
        chk("arst_req", 64'(imem_req), 64'(0));
        chk("arst_pc_en", 64'(PC_en), 64'(0));
        exp_q.delete();
        mem_busy = 1'b0; mem_killed = 1'b0;
        PC = RESET_PC;
        imem_rvalid = 1'b0;
        step();
        step();
        // Release with a stale response arriving while IDLE.
        reset = 1'b1;
        lat = 1;
        id_ready = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        n_pops = 0; pop_pc[0] = '0;
        repeat (6) step();
        chk("post_rst_pop", 64'(pop_pc[0]), 64'(RESET_PC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
